// File: rtl/dec_countdown_if.sv
// Handshake bundle for dec_countdown: load request, pause, registered count
// and the done_valid/done_ready completion handshake.
interface dec_countdown_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic             pause;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start, in, pause, done_ready,
        input  out, busy, done_valid
    );

    modport slave (
        input  start, in, pause, done_ready,
        output out, busy, done_valid
    );
endinterface

// File: rtl/dec_countdown.sv
// Loadable saturating down-counter; completion is reported on done_valid and
// held until the consumer accepts it with done_ready.
module dec_countdown #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dec_countdown_if.slave bus
);

    if (STEP < 1 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
        $error("dec_countdown: STEP must lie in 1 .. 2**WIDTH-1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [WIDTH:0] STEP_W = (WIDTH + 1)'(STEP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count, count_nxt;
    logic             busy, done_valid;
    logic [WIDTH:0]   count_ext, diff;

    // One extra bit so the borrow of count - STEP is never lost before saturation.
    assign count_ext = {1'b0, count};
    assign diff      = count_ext - STEP_W;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    count_nxt = bus.in;
                    state_nxt = (bus.in == '0) ? DONE : COUNT;
                end
            end
            COUNT: begin
                if (!bus.pause) begin
                    if (count_ext > STEP_W) begin
                        count_nxt = WIDTH'(diff);
                    end else begin
                        count_nxt = '0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                count_nxt = '0;
                if (bus.done_ready) state_nxt = IDLE;
            end
            default: begin
                count_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags decode the next state so they flip on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            done_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state      <= state_nxt;
            count      <= count_nxt;
            busy       <= (state_nxt != IDLE);
            done_valid <= (state_nxt == DONE);
        end
    end

    assign bus.out        = count;
    assign bus.busy       = busy;
    assign bus.done_valid = done_valid;

endmodule

// File: doc/dec_countdown.md
# dec_countdown

Loadable down-counter with a valid/ready completion handshake. It is the decrementing counterpart of the increment-driven test modules in the sv test suite. All `--` updates happen legally inside a clocked procedural block; none appear in continuous or procedural-continuous assignments. It serves as a positive (must-pass) design for the sv flow: translation and equivalence against simulation.

## Interface

Parameters:
- WIDTH, 4, width of load value and count.
- STEP, 1, decrement per active cycle.
  - Legal range 1 .. 2**WIDTH-1.
  - Elaboration error outside that range.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request; sampled only in IDLE.
- in  input  WIDTH  load value, sampled with start.
- pause  input  1  freezes the count while in COUNT.
- out  output  WIDTH  current count, registered.
- busy  output  1  high in COUNT and DONE.
- done_valid  output  1  completion indication, held until accepted.
- done_ready  input  1  consumer accepts completion.

## Operation

- The state machine has three states: IDLE, COUNT, DONE. Encoding is free. The state register and all outputs are flops; no combinational path exists from input to output.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out = 0, busy = 0, done_valid = 0.
  - Release is synchronous to clk. The first active edge after release behaves as IDLE.
- IDLE:
  - start=1, in≠0: out ← in; go to COUNT.
  - start=1, in=0: out ← 0; go directly to DONE.
  - start=0: out holds its last value.
- COUNT:
  - pause=1: out and state hold.
  - pause=0, out > STEP: out ← out − STEP.
  - pause=0, out ≤ STEP: out ← 0; go to DONE. Out saturates at 0 and never wraps.
  - start is ignored.
- DONE:
  - done_valid=1 and out=0.
  - done_ready=1: go to IDLE.
  - done_ready=0: hold indefinitely.
  - start and pause are ignored.
- Decode: busy = (state≠IDLE); done_valid = (state==DONE). Both are registered, i.e. derived from the next-state value at each edge.
- Arithmetic:
  - Subtraction is performed in WIDTH+1 bits; the comparison against STEP is unsigned.
  - The result is truncated to WIDTH only after saturation.
  - No X is allowed on out in any reachable state.

## Timing

- Load: start sampled at edge k.
  - out = in and busy = 1 after edge k.
- Countdown, STEP=1, no pause:
  - out = in − n after edge k+n.
  - out = 0 and done_valid = 1 after edge k+in.
- Latency from the start edge to done_valid is ceil(in/STEP) cycles, plus one cycle per paused cycle.
- in=0: done_valid = 1 after edge k (zero-count latency).
- Handshake:
  - done_valid ∧ done_ready at edge m: done_valid = 0 and busy = 0 after edge m.
  - A start presented at edge m is not accepted. The earliest accepted start is at edge m+1.
- pause asserted at the same edge where out would reach 0: no transition; DONE is entered on the first unpaused edge.
- Reset mid-COUNT or mid-DONE: all outputs are 0 immediately, without waiting for clk. A pending completion is discarded, with no done_valid pulse after reset.
- done_ready while not in DONE has no effect.

## Test plan

- Reset, then start=1, in=5, no pause, done_ready=0:
  - out sequence is 5,4,3,2,1,0 on consecutive edges.
  - done_valid rises with out=0 and stays high for 10 cycles.
  - done_ready=1 for one cycle drops done_valid and busy on the next edge.
- start=1, in=0:
  - done_valid=1 and busy=1 after one edge; out=0.
  - Returns to IDLE on done_ready.
- WIDTH=4, STEP=3, in=7: out = 7, 4, 1, 0. DONE is entered at the fourth edge, with no wrap to 14.
- in=15 with pause high for edges 3–6:
  - out holds at 13 during the pause.
  - done_valid arrives 4 cycles later than unpaused (edge 19).
- start pulsed during COUNT with in=9 and again during DONE: both are ignored; the count and completion are unchanged.
- rst_n driven low between clock edges while out=6 in COUNT:
  - out=0, busy=0, done_valid=0 immediately.
  - After release, the module idles until a new start.
